// File: rtl/st7735_spi_sink_if.sv
// Bus bundle for the ST7735 receive model: SPI wires from the driver, decoded events back.
interface st7735_spi_sink_if #(
  parameter int COORD_W = 8
);
  logic               CS;
  logic               MOSI;
  logic               DC;
  logic               LCD_CLK;
  logic               RESET;
  logic               cmd_valid;
  logic [7:0]         cmd_byte;
  logic               pix_valid;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [15:0]        pix_color;
  logic               frame_done;
  logic               sleep_out;
  logic               disp_on;

  modport master (
    output CS, MOSI, DC, LCD_CLK, RESET,
    input  cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_color,
           frame_done, sleep_out, disp_on
  );

  modport slave (
    input  CS, MOSI, DC, LCD_CLK, RESET,
    output cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_color,
           frame_done, sleep_out, disp_on
  );
endinterface

// File: rtl/st7735_spi_sink.sv
// Oversampling ST7735 SPI receiver: byte framing, command decode, CASET/RASET window
// tracking and one pixel event per RAMWR colour word.
module st7735_spi_sink #(
  parameter int WIDTH       = 128,
  parameter int HEIGHT      = 160,
  parameter int COORD_W     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            SYSTEM_CLK,
  input  logic            RST,
  st7735_spi_sink_if.slave bus
);
  localparam logic [COORD_W-1:0] XE_RST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] YE_RST = COORD_W'(HEIGHT - 1);
  localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_CASET, S_RASET, S_RAMWR, S_IGNORE} state_t;

  // Sync bit order: {RESET, LCD_CLK, DC, MOSI, CS}; idle values keep CS and RESET deasserted.
  logic [4:0] w_in;
  logic [SYNC_STAGES-1:0][4:0] r_sync;
  assign w_in = {bus.RESET, bus.LCD_CLK, bus.DC, bus.MOSI, bus.CS};

  always_ff @(posedge SYSTEM_CLK or posedge RST) begin
    if (RST) r_sync <= {SYNC_STAGES{5'b10001}};
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], w_in};
  end

  logic w_cs, w_mosi, w_dc, w_sclk, w_rstn;
  assign {w_rstn, w_sclk, w_dc, w_mosi, w_cs} = r_sync[SYNC_STAGES-1];

  // Byte framing
  logic       r_sclk_d;
  logic [2:0] r_bcnt;
  logic [6:0] r_shift;
  logic       r_stb;
  logic [7:0] r_byte;
  logic       r_dc;

  always_ff @(posedge SYSTEM_CLK or posedge RST) begin
    if (RST) begin
      r_sclk_d <= 1'b0;
      r_bcnt   <= 3'd0;
      r_shift  <= 7'd0;
      r_stb    <= 1'b0;
      r_byte   <= 8'd0;
      r_dc     <= 1'b0;
    end else begin
      r_sclk_d <= w_sclk;
      r_stb    <= 1'b0;
      if (!w_rstn || w_cs) begin
        r_bcnt <= 3'd0;
      end else if (w_sclk && !r_sclk_d) begin
        r_shift <= {r_shift[5:0], w_mosi};
        r_bcnt  <= r_bcnt + 3'd1;
        if (r_bcnt == 3'd7) begin
          r_stb  <= 1'b1;
          r_byte <= {r_shift, w_mosi};
          r_dc   <= w_dc;
        end
      end
    end
  end

  // Decode
  state_t             r_state;
  logic [1:0]         r_pidx;
  logic [7:0]         r_phi;
  logic [COORD_W-1:0] r_start;
  logic               r_hiph;
  logic [COORD_W-1:0] r_xs, r_xe, r_ys, r_ye, r_x, r_y;
  logic               w_cmd, w_data, w_soft_rst;

  assign w_cmd      = w_rstn && r_stb && !r_dc;
  assign w_data     = w_rstn && r_stb &&  r_dc;
  assign w_soft_rst = !w_rstn || (w_cmd && r_byte == 8'h01);

  always_ff @(posedge SYSTEM_CLK or posedge RST) begin
    if (RST) begin
      r_state        <= S_IDLE;
      r_pidx         <= 2'd0;
      r_phi          <= 8'd0;
      r_start        <= '0;
      r_hiph         <= 1'b1;
      r_xs           <= '0;
      r_xe           <= XE_RST;
      r_ys           <= '0;
      r_ye           <= YE_RST;
      r_x            <= '0;
      r_y            <= '0;
      bus.cmd_valid  <= 1'b0;
      bus.cmd_byte   <= 8'h00;
      bus.pix_valid  <= 1'b0;
      bus.pix_x      <= '0;
      bus.pix_y      <= '0;
      bus.pix_color  <= 16'h0000;
      bus.frame_done <= 1'b0;
      bus.sleep_out  <= 1'b0;
      bus.disp_on    <= 1'b0;
    end else begin
      bus.cmd_valid  <= 1'b0;
      bus.pix_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      if (w_cmd) begin
        bus.cmd_valid <= 1'b1;
        bus.cmd_byte  <= r_byte;
        r_pidx        <= 2'd0;
        r_hiph        <= 1'b1;
        case (r_byte)
          8'h2A: r_state <= S_CASET;
          8'h2B: r_state <= S_RASET;
          8'h2C: begin
            r_state <= S_RAMWR;
            r_x     <= r_xs;
            r_y     <= r_ys;
          end
          8'h01: r_state <= S_IDLE;
          8'h10: begin bus.sleep_out <= 1'b0; r_state <= S_IDLE; end
          8'h11: begin bus.sleep_out <= 1'b1; r_state <= S_IDLE; end
          8'h28: begin bus.disp_on   <= 1'b0; r_state <= S_IDLE; end
          8'h29: begin bus.disp_on   <= 1'b1; r_state <= S_IDLE; end
          default: r_state <= S_IGNORE;
        endcase
      end else if (w_data) begin
        case (r_state)
          S_CASET, S_RASET: begin
            r_pidx <= r_pidx + 2'd1;
            case (r_pidx)
              2'd1: r_start <= COORD_W'({r_phi, r_byte});
              2'd3: begin
                // Window commits only once the full 4-byte parameter set has arrived.
                if (r_state == S_CASET) begin
                  r_xs <= r_start;
                  r_xe <= COORD_W'({r_phi, r_byte});
                end else begin
                  r_ys <= r_start;
                  r_ye <= COORD_W'({r_phi, r_byte});
                end
                r_state <= S_IDLE;
              end
              default: r_phi <= r_byte;
            endcase
          end
          S_RAMWR: begin
            if (r_hiph) begin
              r_phi  <= r_byte;
              r_hiph <= 1'b0;
            end else begin
              r_hiph         <= 1'b1;
              bus.pix_valid  <= 1'b1;
              bus.pix_x      <= r_x;
              bus.pix_y      <= r_y;
              bus.pix_color  <= {r_phi, r_byte};
              bus.frame_done <= (r_x == r_xe) && (r_y == r_ye);
              // XS>XE simply runs x through the COORD_W wrap until it meets XE.
              if (r_x == r_xe) begin
                r_x <= r_xs;
                r_y <= (r_y == r_ye) ? r_ys : r_y + C_ONE;
              end else begin
                r_x <= r_x + C_ONE;
              end
            end
          end
          default: ;
        endcase
      end
      if (w_soft_rst) begin
        r_state       <= S_IDLE;
        r_xs          <= '0;
        r_xe          <= XE_RST;
        r_ys          <= '0;
        r_ye          <= YE_RST;
        bus.sleep_out <= 1'b0;
        bus.disp_on   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_st7735_spi_sink.sv
// Directed bench for st7735_spi_sink: byte table with expected events plus hand sequences.
module tb_st7735_spi_sink;
  logic clk, rst;
  st7735_spi_sink_if #(.COORD_W(8)) bus();

  st7735_spi_sink #(.WIDTH(128), .HEIGHT(160), .COORD_W(8), .SYNC_STAGES(2)) dut (
    .SYSTEM_CLK(clk), .RST(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         dc;
    logic [7:0] b;
    bit         ecmd;
    bit         epix;
    logic [7:0] ex, ey;
    logic [15:0] ecol;
    bit         efd;
  } tv_t;

  tv_t tv[$];
  int n_chk = 0, n_fail = 0;
  int cmd_cnt = 0, pix_cnt = 0, both_cnt = 0;
  logic [7:0]  last_cmd;
  logic [7:0]  last_x, last_y;
  logic [15:0] last_col;
  logic        last_fd;

  always @(negedge clk) begin
    if (bus.cmd_valid) begin cmd_cnt++; last_cmd = bus.cmd_byte; end
    if (bus.pix_valid) begin
      pix_cnt++; last_x = bus.pix_x; last_y = bus.pix_y;
      last_col = bus.pix_color; last_fd = bus.frame_done;
    end
    if (bus.cmd_valid && bus.pix_valid) both_cnt++;
  end

  function automatic tv_t mk_c(input logic [7:0] b);
    tv_t t = '{dc:1'b0, b:b, ecmd:1'b1, epix:1'b0, ex:8'h0, ey:8'h0, ecol:16'h0, efd:1'b0};
    return t;
  endfunction
  function automatic tv_t mk_d(input logic [7:0] b);
    tv_t t = '{dc:1'b1, b:b, ecmd:1'b0, epix:1'b0, ex:8'h0, ey:8'h0, ecol:16'h0, efd:1'b0};
    return t;
  endfunction
  function automatic tv_t mk_p(input logic [7:0] b, input logic [7:0] x, input logic [7:0] y,
                               input logic [15:0] col, input bit fd);
    tv_t t = '{dc:1'b1, b:b, ecmd:1'b0, epix:1'b1, ex:x, ey:y, ecol:col, efd:fd};
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input bit dc, input int n);
    for (int i = 0; i < n; i++) begin
      bus.MOSI = b[7-i]; bus.DC = dc; bus.LCD_CLK = 1'b0;
      cyc(4);
      bus.LCD_CLK = 1'b1;
      cyc(4);
    end
    bus.LCD_CLK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit dc);
    send_bits(b, dc, 8);
    cyc(6);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    int cc, pc;
    for (int i = lo; i < hi; i++) begin
      cc = cmd_cnt; pc = pix_cnt;
      send_byte(tv[i].b, tv[i].dc);
      chk($sformatf("v%0d cmd_count", i), cmd_cnt - cc, tv[i].ecmd ? 1 : 0);
      chk($sformatf("v%0d pix_count", i), pix_cnt - pc, tv[i].epix ? 1 : 0);
      if (tv[i].ecmd) begin
        chk($sformatf("v%0d cmd_byte", i), last_cmd, tv[i].b);
        chk($sformatf("v%0d cmd_hold", i), bus.cmd_byte, tv[i].b);
      end
      if (tv[i].epix) begin
        chk($sformatf("v%0d pix_x", i), last_x, tv[i].ex);
        chk($sformatf("v%0d pix_y", i), last_y, tv[i].ey);
        chk($sformatf("v%0d pix_color", i), last_col, tv[i].ecol);
        chk($sformatf("v%0d frame_done", i), last_fd, tv[i].efd);
      end
    end
  endtask

  initial begin
    int n1, cc, pc, k;
    // Part 1: display on, sleep out, 2x2 window at (2..3, 5..6), five RAMWR words
    tv.push_back(mk_c(8'h29)); tv.push_back(mk_c(8'h11));
    tv.push_back(mk_c(8'h2A)); tv.push_back(mk_d(8'h00)); tv.push_back(mk_d(8'h02));
    tv.push_back(mk_d(8'h00)); tv.push_back(mk_d(8'h03));
    tv.push_back(mk_c(8'h2B)); tv.push_back(mk_d(8'h00)); tv.push_back(mk_d(8'h05));
    tv.push_back(mk_d(8'h00)); tv.push_back(mk_d(8'h06));
    tv.push_back(mk_c(8'h2C));
    tv.push_back(mk_d(8'hF8)); tv.push_back(mk_p(8'h00, 8'd2, 8'd5, 16'hF800, 1'b0));
    tv.push_back(mk_d(8'h07)); tv.push_back(mk_p(8'hE0, 8'd3, 8'd5, 16'h07E0, 1'b0));
    tv.push_back(mk_d(8'h00)); tv.push_back(mk_p(8'h1F, 8'd2, 8'd6, 16'h001F, 1'b0));
    tv.push_back(mk_d(8'hFF)); tv.push_back(mk_p(8'hFF, 8'd3, 8'd6, 16'hFFFF, 1'b1));
    tv.push_back(mk_d(8'h12)); tv.push_back(mk_p(8'h34, 8'd2, 8'd5, 16'h1234, 1'b0));
    n1 = tv.size();
    // Part 2: SWRESET, truncated CASET, RAMWR from origin, unknown command with data, RAMWR again
    tv.push_back(mk_c(8'h01));
    tv.push_back(mk_c(8'h2A)); tv.push_back(mk_d(8'h00)); tv.push_back(mk_d(8'h10));
    tv.push_back(mk_d(8'h00));
    tv.push_back(mk_c(8'h2C));
    tv.push_back(mk_d(8'hAB)); tv.push_back(mk_p(8'hCD, 8'd0, 8'd0, 16'hABCD, 1'b0));
    tv.push_back(mk_d(8'h12)); tv.push_back(mk_p(8'h34, 8'd1, 8'd0, 16'h1234, 1'b0));
    tv.push_back(mk_c(8'hB1)); tv.push_back(mk_d(8'h01)); tv.push_back(mk_d(8'h2C));
    tv.push_back(mk_d(8'h2D));
    tv.push_back(mk_c(8'h2C));
    tv.push_back(mk_d(8'h55)); tv.push_back(mk_p(8'h66, 8'd0, 8'd0, 16'h5566, 1'b0));

    bus.CS = 1'b1; bus.MOSI = 1'b0; bus.DC = 1'b0; bus.LCD_CLK = 1'b0; bus.RESET = 1'b1;
    rst = 1'b1;
    cyc(3);
    chk("rst cmd_valid", bus.cmd_valid, 0);
    chk("rst cmd_byte", bus.cmd_byte, 8'h00);
    chk("rst pix_valid", bus.pix_valid, 0);
    chk("rst frame_done", bus.frame_done, 0);
    chk("rst sleep_out", bus.sleep_out, 0);
    chk("rst disp_on", bus.disp_on, 0);
    chk("rst pix_color", bus.pix_color, 16'h0);
    rst = 1'b0;
    cyc(4);
    bus.CS = 1'b0;
    cyc(4);

    run_vecs(0, n1);
    chk("disp_on after 29", bus.disp_on, 1);
    chk("sleep_out after 11", bus.sleep_out, 1);

    // Partial byte killed by CS; next word lands at (3,5)
    send_bits(8'hA5, 1'b1, 5);
    cyc(2);
    bus.CS = 1'b1; cyc(6); bus.CS = 1'b0; cyc(4);
    pc = pix_cnt;
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    chk("cs abort pix_count", pix_cnt - pc, 1);
    chk("cs abort color", last_col, 16'h5678);
    chk("cs abort x", last_x, 8'd3);
    chk("cs abort y", last_y, 8'd5);

    run_vecs(n1, tv.size());
    chk("disp_on after swreset", bus.disp_on, 0);
    chk("sleep_out after swreset", bus.sleep_out, 0);

    // Command-to-pulse latency: cmd_valid on the 4th rising edge after LCD_CLK rises
    send_bits(8'h29, 1'b0, 7);
    bus.MOSI = 1'b1; bus.LCD_CLK = 1'b0;
    cyc(4);
    bus.LCD_CLK = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.cmd_valid) begin k = i; break; end
    end
    chk("cmd latency", k, 4);
    cyc(1);
    chk("cmd pulse width", bus.cmd_valid, 0);
    bus.LCD_CLK = 1'b0;
    cyc(6);
    chk("disp_on latency seq", bus.disp_on, 1);
    send_byte(8'h11, 1'b0);
    chk("sleep_out set", bus.sleep_out, 1);

    // Panel reset in the middle of RAMWR with a half-received word
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h07, 1'b1);
    send_byte(8'h2C, 1'b0);
    send_byte(8'h9A, 1'b1); send_byte(8'hBC, 1'b1);
    chk("win pixel x", last_x, 8'd5);
    chk("win pixel color", last_col, 16'h9ABC);
    send_byte(8'hDE, 1'b1);
    cc = cmd_cnt;
    bus.RESET = 1'b0; cyc(10); bus.RESET = 1'b1; cyc(6);
    chk("panel rst cmd_count", cmd_cnt - cc, 0);
    chk("panel rst disp_on", bus.disp_on, 0);
    chk("panel rst sleep_out", bus.sleep_out, 0);
    pc = pix_cnt;
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    chk("panel rst no pixels", pix_cnt - pc, 0);
    send_byte(8'h2C, 1'b0);
    send_byte(8'hF0, 1'b1); send_byte(8'h0F, 1'b1);
    chk("panel rst pix_count", pix_cnt - pc, 1);
    chk("panel rst pix x", last_x, 8'd0);
    chk("panel rst pix y", last_y, 8'd0);
    chk("panel rst color", last_col, 16'hF00F);

    chk("cmd and pix never together", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
